// File: rtl/ppu_pkg.sv
// Shared sizes, types and helpers for the PPU pixel-output path.
package ppu_pkg;

  localparam int PAL_ENTRIES = 32;
  localparam int VIS_W       = 256;
  localparam int VIS_H       = 240;

  typedef logic [4:0] pal_addr_t;
  typedef logic [5:0] nes_color_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Sprite backdrop slots $10/$14/$18/$1C alias the background backdrops.
  function automatic pal_addr_t pal_mirror(input pal_addr_t a);
    if (a[4] && (a[1:0] == 2'b00)) begin
      return {1'b0, a[3:0]};
    end else begin
      return a;
    end
  endfunction

  // A channel dims to 3/4 when any emphasis bit is set but not its own.
  function automatic logic [7:0] emph_apply(input logic [7:0] v, input logic [2:0] emph,
                                            input logic own_bit);
    if ((emph != 3'b000) && !own_bit) begin
      return v - (v >> 2);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/ppu_color_rom.sv
// Combinational 2C02 colour ROM: 6-bit NES colour index to 24-bit RGB.
module ppu_color_rom
  import ppu_pkg::*;
(
  input  nes_color_t idx,
  output rgb_t       rgb
);

  logic [23:0] rom_s;

  // Unlisted indices ($0D-$0F, $1D-$1F, $2E-$2F, $3E-$3F) fall to black.
  always_comb begin
    rom_s = 24'h000000;
    case (idx)
      6'h00: rom_s = 24'h545454;  6'h01: rom_s = 24'h001E74;
      6'h02: rom_s = 24'h081090;  6'h03: rom_s = 24'h300088;
      6'h04: rom_s = 24'h440064;  6'h05: rom_s = 24'h5C0030;
      6'h06: rom_s = 24'h540400;  6'h07: rom_s = 24'h3C1800;
      6'h08: rom_s = 24'h202A00;  6'h09: rom_s = 24'h083A00;
      6'h0A: rom_s = 24'h004000;  6'h0B: rom_s = 24'h003C00;
      6'h0C: rom_s = 24'h00323C;
      6'h10: rom_s = 24'h989698;  6'h11: rom_s = 24'h084CC4;
      6'h12: rom_s = 24'h3032EC;  6'h13: rom_s = 24'h5C1EE4;
      6'h14: rom_s = 24'h8814B0;  6'h15: rom_s = 24'hA01464;
      6'h16: rom_s = 24'h982220;  6'h17: rom_s = 24'h783C00;
      6'h18: rom_s = 24'h545A00;  6'h19: rom_s = 24'h287200;
      6'h1A: rom_s = 24'h087C00;  6'h1B: rom_s = 24'h007628;
      6'h1C: rom_s = 24'h006678;
      6'h20: rom_s = 24'hECEEEC;  6'h21: rom_s = 24'h4C9AEC;
      6'h22: rom_s = 24'h787CEC;  6'h23: rom_s = 24'hB062EC;
      6'h24: rom_s = 24'hE454EC;  6'h25: rom_s = 24'hEC58B4;
      6'h26: rom_s = 24'hEC6A64;  6'h27: rom_s = 24'hD48820;
      6'h28: rom_s = 24'hA0AA00;  6'h29: rom_s = 24'h74C400;
      6'h2A: rom_s = 24'h4CD020;  6'h2B: rom_s = 24'h38CC6C;
      6'h2C: rom_s = 24'h38B4CC;  6'h2D: rom_s = 24'h3C3C3C;
      6'h30: rom_s = 24'hECEEEC;  6'h31: rom_s = 24'hA8CCEC;
      6'h32: rom_s = 24'hBCBCEC;  6'h33: rom_s = 24'hD4B2EC;
      6'h34: rom_s = 24'hECAEEC;  6'h35: rom_s = 24'hECAED4;
      6'h36: rom_s = 24'hECB4B0;  6'h37: rom_s = 24'hE4C490;
      6'h38: rom_s = 24'hCCD278;  6'h39: rom_s = 24'hB4DE78;
      6'h3A: rom_s = 24'hA8E290;  6'h3B: rom_s = 24'h98E2B4;
      6'h3C: rom_s = 24'hA0D6E4;  6'h3D: rom_s = 24'hA0A2A0;
      default: rom_s = 24'h000000;
    endcase
  end

  assign rgb = rom_s;

endmodule

// File: rtl/ppu_palette_out.sv
// PPU pixel-output stage: palette RAM lookup, grayscale/emphasis, registered RGB,
// plus the CPU-side palette read/write port.
module ppu_palette_out
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pixel,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       grayscale,
  input  logic [2:0] emphasis,
  input  logic       pal_we,
  input  logic       pal_re,
  input  logic [4:0] pal_addr,
  input  logic [5:0] pal_wdata,
  output logic [5:0] pal_rdata,
  output logic       out_valid,
  output logic [8:0] out_x,
  output logic [7:0] out_y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  nes_color_t pal_mem_r [PAL_ENTRIES];

  pal_addr_t  cpu_addr_s;
  pal_addr_t  lookup_addr_s;
  logic       visible_s;

  pal_addr_t  s1_addr_r;
  logic       s1_gray_r;
  logic [2:0] s1_emph_r;
  logic       s1_vis_r;
  logic [8:0] s1_x_r;
  logic [7:0] s1_y_r;

  nes_color_t s2_idx_r;
  logic [2:0] s2_emph_r;
  logic       s2_vis_r;
  logic [8:0] s2_x_r;
  logic [7:0] s2_y_r;

  rgb_t       rom_rgb_s;

  // Address decode for the CPU port and the render lookup.
  always_comb begin
    cpu_addr_s = pal_mirror(pal_addr);
    if (pixel[1:0] == 2'b00) begin
      lookup_addr_s = 5'h00;
    end else begin
      lookup_addr_s = pal_mirror(pixel);
    end
    visible_s = (x_idx < 10'(VIS_W)) && (scanline < 10'(VIS_H));
  end

  // Palette storage; CPU writes land at the edge and reads see pre-write data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_mem_r[i] <= 6'd0;
      end
      pal_rdata <= 6'd0;
    end else begin
      if (pal_we) begin
        pal_mem_r[cpu_addr_s] <= pal_wdata;
      end
      if (pal_re) begin
        pal_rdata <= pal_mem_r[cpu_addr_s];
      end
    end
  end

  // Stage 1: capture lookup address and the mask bits that travel with the pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_addr_r <= 5'd0;
      s1_gray_r <= 1'b0;
      s1_emph_r <= 3'd0;
      s1_vis_r  <= 1'b0;
      s1_x_r    <= 9'd0;
      s1_y_r    <= 8'd0;
    end else begin
      s1_addr_r <= lookup_addr_s;
      s1_gray_r <= grayscale;
      s1_emph_r <= emphasis;
      s1_vis_r  <= visible_s;
      s1_x_r    <= x_idx[8:0];
      s1_y_r    <= scanline[7:0];
    end
  end

  // Stage 2: palette read with grayscale keeping only the luma row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_idx_r  <= 6'd0;
      s2_emph_r <= 3'd0;
      s2_vis_r  <= 1'b0;
      s2_x_r    <= 9'd0;
      s2_y_r    <= 8'd0;
    end else begin
      s2_idx_r  <= pal_mem_r[s1_addr_r] & (s1_gray_r ? 6'h30 : 6'h3F);
      s2_emph_r <= s1_emph_r;
      s2_vis_r  <= s1_vis_r;
      s2_x_r    <= s1_x_r;
      s2_y_r    <= s1_y_r;
    end
  end

  ppu_color_rom u_rom (
    .idx (s2_idx_r),
    .rgb (rom_rgb_s)
  );

  // Stage 3: colour conversion and emphasis; blanked outside the visible area.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_x     <= 9'd0;
      out_y     <= 8'd0;
      r         <= 8'd0;
      g         <= 8'd0;
      b         <= 8'd0;
    end else begin
      out_valid <= s2_vis_r;
      if (s2_vis_r) begin
        out_x <= s2_x_r;
        out_y <= s2_y_r;
        r     <= emph_apply(rom_rgb_s.r, s2_emph_r, s2_emph_r[0]);
        g     <= emph_apply(rom_rgb_s.g, s2_emph_r, s2_emph_r[1]);
        b     <= emph_apply(rom_rgb_s.b, s2_emph_r, s2_emph_r[2]);
      end else begin
        out_x <= 9'd0;
        out_y <= 8'd0;
        r     <= 8'd0;
        g     <= 8'd0;
        b     <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_palette_out.sv
// Self-checking bench for ppu_palette_out: directed scenarios plus random traffic
// against a palette/pipeline reference model.
module tb_ppu_palette_out;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pixel;
  logic [9:0] x_idx, scanline;
  logic       grayscale;
  logic [2:0] emphasis;
  logic       pal_we, pal_re;
  logic [4:0] pal_addr;
  logic [5:0] pal_wdata, pal_rdata;
  logic       out_valid;
  logic [8:0] out_x;
  logic [7:0] out_y, r, g, b;

  int total = 0;
  int bad   = 0;

  localparam logic [23:0] ROM_TBL [64] = '{
    24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
    24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
    24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
    24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
    24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
    24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
    24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
    24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
  };

  typedef struct {
    logic        vis;
    logic [23:0] rgb;
    logic [8:0]  x;
    logic [7:0]  y;
  } exp_t;

  exp_t       exp_q [$];
  logic [5:0] mdl_mem [32];
  logic [5:0] mdl_rdata;

  ppu_palette_out dut (
    .clk       (clk),
    .reset     (reset),
    .pixel     (pixel),
    .x_idx     (x_idx),
    .scanline  (scanline),
    .grayscale (grayscale),
    .emphasis  (emphasis),
    .pal_we    (pal_we),
    .pal_re    (pal_re),
    .pal_addr  (pal_addr),
    .pal_wdata (pal_wdata),
    .pal_rdata (pal_rdata),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] mir(input logic [4:0] a);
    return (a[4] && a[1:0] == 2'd0) ? {1'b0, a[3:0]} : a;
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] v);
    return v - v / 8'd4;
  endfunction

  // Model state after a reset: zero palette, empty pipe showing blank outputs.
  task automatic model_reset();
    exp_t z;
    for (int i = 0; i < 32; i++) mdl_mem[i] = 6'd0;
    mdl_rdata = 6'd0;
    exp_q.delete();
    z.vis = 1'b0; z.rgb = 24'd0; z.x = 9'd0; z.y = 8'd0;
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One dot: drive inputs, predict, clock, then compare the pixel from 3 dots ago.
  task automatic step(input logic [4:0] pix, input logic [9:0] xi, input logic [9:0] yi,
                      input logic gr, input logic [2:0] em, input logic we, input logic re,
                      input logic [4:0] ad, input logic [5:0] wd);
    exp_t        e;
    logic [5:0]  c;
    logic [23:0] rgb;
    pixel = pix; x_idx = xi; scanline = yi; grayscale = gr; emphasis = em;
    pal_we = we; pal_re = re; pal_addr = ad; pal_wdata = wd;
    if (re) mdl_rdata = mdl_mem[mir(ad)];
    if (we) mdl_mem[mir(ad)] = wd;
    c = (pix[1:0] == 2'd0) ? mdl_mem[0] : mdl_mem[mir(pix)];
    if (gr) c = c & 6'h30;
    rgb = ROM_TBL[c];
    if (em != 3'd0) begin
      if (!em[0]) rgb[23:16] = dim(rgb[23:16]);
      if (!em[1]) rgb[15:8]  = dim(rgb[15:8]);
      if (!em[2]) rgb[7:0]   = dim(rgb[7:0]);
    end
    e.vis = (xi < 10'd256) && (yi < 10'd240);
    e.rgb = e.vis ? rgb : 24'd0;
    e.x   = xi[8:0];
    e.y   = yi[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", {31'd0, out_valid}, {31'd0, e.vis});
    check("rgb", {8'd0, r, g, b}, {8'd0, e.rgb});
    if (e.vis) begin
      check("out_x", {23'd0, out_x}, {23'd0, e.x});
      check("out_y", {24'd0, out_y}, {24'd0, e.y});
    end
    check("pal_rdata", {26'd0, pal_rdata}, {26'd0, mdl_rdata});
  endtask

  task automatic idle_inputs();
    pixel = 5'd0; x_idx = 10'd0; scanline = 10'd0; grayscale = 1'b0; emphasis = 3'd0;
    pal_we = 1'b0; pal_re = 1'b0; pal_addr = 5'd0; pal_wdata = 6'd0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_rgb", {8'd0, r, g, b}, 32'd0);
    check("reset_rdata", {26'd0, pal_rdata}, 32'd0);
    reset = 1'b1;
    model_reset();

    // Basic lookup and backdrop.
    step(5'h00, 10'd0,  10'd0,  1'b0, 3'd0, 1'b1, 1'b0, 5'h00, 6'h0F);
    step(5'h00, 10'd0,  10'd0,  1'b0, 3'd0, 1'b1, 1'b0, 5'h05, 6'h16);
    step(5'h05, 10'd10, 10'd20, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h04, 10'd11, 10'd20, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    // Mirrored backdrop write, read through the alias, render the sprite backdrop.
    step(5'h05, 10'd12, 10'd20, 1'b0, 3'd0, 1'b1, 1'b0, 5'h10, 6'h21);
    step(5'h05, 10'd13, 10'd20, 1'b0, 3'd0, 1'b0, 1'b1, 5'h00, 6'h00);
    step(5'h10, 10'd14, 10'd20, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    // Grayscale, then red emphasis.
    step(5'h05, 10'd15, 10'd20, 1'b1, 3'd0,   1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h05, 10'd16, 10'd20, 1'b0, 3'b001, 1'b0, 1'b0, 5'h00, 6'h00);
    // Just outside the visible window on each axis.
    step(5'h05, 10'd256, 10'd20,  1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h05, 10'd255, 10'd240, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h05, 10'd255, 10'd239, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    // Write at the edge the earlier pixel reaches stage 2; the later pixel sees it.
    step(5'h05, 10'd1, 10'd1, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h05, 10'd2, 10'd1, 1'b0, 3'd0, 1'b1, 1'b0, 5'h05, 6'h2A);
    step(5'h05, 10'd3, 10'd1, 1'b0, 3'd0, 1'b1, 1'b1, 5'h05, 6'h01);
    step(5'h00, 10'd4, 10'd1, 1'b0, 3'd0, 1'b0, 1'b1, 5'h15, 6'h00);
    repeat (3) step(5'h00, 10'd5, 10'd1, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom), 10'($urandom_range(0, 300)), 10'($urandom_range(0, 262)),
           ($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom), 6'($urandom));
    end

    // Reset with three pixels in flight.
    step(5'h01, 10'd30, 10'd30, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h02, 10'd31, 10'd30, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h03, 10'd32, 10'd30, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_rgb", {8'd0, r, g, b}, 32'd0);
    check("async_xy", {15'd0, out_x, out_y}, 32'd0);
    check("async_rdata", {26'd0, pal_rdata}, 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    step(5'h07, 10'd300, 10'd5, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    step(5'h06, 10'd40,  10'd5, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);
    for (int a = 0; a < 32; a++) begin
      step(5'h06, 10'(41 + a), 10'd5, 1'b0, 3'd0, 1'b0, 1'b1, 5'(a), 6'h00);
    end
    repeat (3) step(5'h00, 10'd0, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'h00, 6'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
